pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline stage register, successor to the fixed-field inter-stage latches. It carries an opaque WIDTH-bit payload between two stages with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never creates a combinational ready path. It also supports synchronous flush, a sticky halt that blocks younger entries, and a saturating stall counter. It drops in between any two pipeline stages (e.g. EX→MEM) once the stage controls move to handshakes.

## Interface

Parameters:
- WIDTH, 64, payload width in bits (≥1)
- CNT_W, 16, stall counter width (≥2)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- flush  in  1  discard all held entries and clear the halt block
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; driven from registers only
- in_data  in  WIDTH  upstream payload
- in_halt  in  1  entry is a halt marker
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head
- out_data  out  WIDTH  head payload
- out_halt  out  1  head entry's halt bit
- occupancy  out  2  held entries, 0..2
- halted  out  1  sticky; a halt entry has left through the output
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation

- Storage consists of two slots: main (head, drives out_*) and skid. Each slot holds data, a halt bit and a valid bit.
- Handshakes:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- in_ready = !skid_valid & !block. It never depends on out_ready or in_valid.
- block is set when an entry with in_halt=1 is accepted (in_fire). It is cleared only by flush or reset.
- The state is the occupancy count. Transitions without flush:
  - EMPTY(0), in_fire → ONE; main ← in.
  - ONE, in_fire & out_fire → ONE; main ← in.
  - ONE, in_fire & !out_fire → TWO; skid ← in.
  - ONE, out_fire only → EMPTY.
  - TWO (in_ready=0), out_fire → ONE; main ← skid; skid cleared.
  - Any state, no fire → hold.
- Ordering is strict FIFO. Skid always holds the younger entry.
- flush (when nRST=1) has priority over every transition:
  - Both valids, data and halt bits are zeroed.
  - block is cleared.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as delivered, so downstream keeps that entry.
- halted sets on an out_fire with out_halt=1. It is cleared only by reset; flush does not clear it.
- stall_cnt increments on each cycle with out_valid & !out_ready. It saturates at 2^CNT_W−1 and is cleared only by reset.
- Invalid slots hold zero data. out_data and out_halt are zero whenever out_valid=0.

## Timing

- Reset: sampled on a rising edge with nRST=0. After that edge all of the following are 0: out_valid, out_data, out_halt, occupancy, halted, stall_cnt, skid, block. in_ready=1 after that edge.
- Latency: an entry accepted at edge N appears on out_* after edge N. Minimum stage latency is 1 cycle.
- Throughput: 1 entry/cycle while out_ready=1.
- Back-pressure: when out_ready drops, the stage absorbs one more entry into skid. in_ready falls at the following edge.
- Boundary cases:
  - Full (TWO) with out_fire: in_ready returns to 1 the next cycle. No input is accepted in the draining cycle.
  - Halt accepted while ONE: a halt entry already in skid still drains normally. No younger entry is accepted.
  - Simultaneous flush and a halt at the input: the halt is discarded, and block stays clear.
  - Reset mid-operation: takes precedence over flush and all handshakes. Held entries are lost.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Test plan

- Streaming: out_ready=1, present A,B,C on consecutive cycles. Required: out_data shows A,B,C on the three following cycles; occupancy stays 1; stall_cnt=0.
- Back-pressure:
  - Stimulus: out_ready=0 while A then B are accepted.
  - Required: occupancy=2 and in_ready=0; out_data=A; stall_cnt increments every cycle.
  - Then raise out_ready: A then B are delivered, and in_ready=1 one cycle after B moves to main.
- Flush while full: with A in main and B in skid, assert flush together with in_valid=C. Required next cycle: out_valid=0, occupancy=0, in_ready=1; C is never output.
- Halt blocking:
  - Stimulus: accept H (in_halt=1), then hold in_valid=1 with D.
  - Required: in_ready=0 after H is accepted; H is delivered with out_halt=1; halted=1 after that edge; D is never accepted until flush.
- Saturation: with CNT_W=2, hold out_valid=1 and out_ready=0 for 6 cycles. Required: stall_cnt reads 1,2,3,3,3,3.
- Reset mid-stream: pulse nRST=0 while occupancy=2. Required: after the edge, every output is at its reset value and in_ready=1.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a 2-entry skid buffer.
// Back-pressure is absorbed by the skid slot, so in_ready is a pure register
// decode. Also provides flush, a sticky halt block and a saturating stall count.
module pipe_skid_stage #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic [1:0]       occupancy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  // The occupancy count is the state; slot valid bits are decoded from it.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam logic [CNT_W-1:0] STALL_MAX = '1;
  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

  occ_e             state, state_next;
  logic [WIDTH-1:0] main_data, main_data_next;
  logic [WIDTH-1:0] skid_data, skid_data_next;
  logic             main_halt, main_halt_next;
  logic             skid_halt, skid_halt_next;
  logic             block, block_next;
  logic             in_fire, out_fire;

  // ready/valid come straight from registers: no in_* -> out_* path and no
  // out_ready -> in_ready path.
  assign in_ready  = (state != TWO) && !block;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_halt  = main_halt;
  assign occupancy = state;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next-state and slot contents; flush overrides every transition.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next     = state;
    main_data_next = main_data;
    main_halt_next = main_halt;
    skid_data_next = skid_data;
    skid_halt_next = skid_halt;
    block_next     = block || (in_fire && in_halt);

    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next     = ONE;
          main_data_next = in_data;
          main_halt_next = in_halt;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_next = in_data;
          main_halt_next = in_halt;
        end else if (in_fire) begin
          state_next     = TWO;
          skid_data_next = in_data;
          skid_halt_next = in_halt;
        end else if (out_fire) begin
          // Invalid slots read as zero.
          state_next     = EMPTY;
          main_data_next = '0;
          main_halt_next = 1'b0;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain can happen.
        if (out_fire) begin
          state_next     = ONE;
          main_data_next = skid_data;
          main_halt_next = skid_halt;
          skid_data_next = '0;
          skid_halt_next = 1'b0;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // An out_fire this cycle is still delivered; an in_fire is discarded.
    if (flush) begin
      state_next     = EMPTY;
      main_data_next = '0;
      main_halt_next = 1'b0;
      skid_data_next = '0;
      skid_halt_next = 1'b0;
      block_next     = 1'b0;
    end
  end

  // Slot and block registers.
  always_ff @(posedge CLK) begin
    // NOTE: the payload registers are reset too, because empty slots must
    // present zero on out_data; they are not a plain storage array.
    if (!nRST) begin
      state     <= EMPTY;
      main_data <= '0;
      main_halt <= 1'b0;
      skid_data <= '0;
      skid_halt <= 1'b0;
      block     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state     <= state_next;
      main_data <= main_data_next;
      main_halt <= main_halt_next;
      skid_data <= skid_data_next;
      skid_halt <= skid_halt_next;
      block     <= block_next;
    end
  end

  // Sticky halted flag and saturating stall counter; only reset clears them.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (out_fire && out_halt) begin
        halted <= 1'b1;
      end
      if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + STALL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: scoreboard bench. The reference model is a plain queue
// of held entries plus a block flag; the monitor pops on each output transfer.
module tb_pipe_skid_stage;

  localparam int W     = 16;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0] data;
    logic         halt;
  } entry_t;

  // Main DUT signals
  logic         CLK;
  logic         nRST;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_halt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_halt;
  logic [1:0]   occupancy;
  logic         halted;
  logic [CW-1:0] stall_cnt;

  // Saturation DUT signals (CNT_W = 2)
  logic         s_flush;
  logic         s_in_valid;
  logic         s_in_ready;
  logic [7:0]   s_in_data;
  logic         s_in_halt;
  logic         s_out_valid;
  logic         s_out_ready;
  logic [7:0]   s_out_data;
  logic         s_out_halt;
  logic [1:0]   s_occupancy;
  logic         s_halted;
  logic [1:0]   s_stall_cnt;

  pipe_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
    .occupancy(occupancy), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_halt(s_in_halt),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_halt(s_out_halt),
    .occupancy(s_occupancy), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  entry_t exp_q[$];
  entry_t mon_e;
  int     model_occ;
  int     model_stall;
  bit     model_blk;
  bit     model_halted;
  bit     pend_flush;

  int n_checks;
  int n_errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: runs mid-cycle; decides the transfer of the coming edge.
  always @(negedge CLK) begin
    if (nRST) begin
      if (model_occ != 0 && !out_ready && model_stall < SMAX) model_stall++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 64'(out_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(mon_e.data));
          check("out_halt", 64'(out_halt), 64'(mon_e.halt));
          if (mon_e.halt) model_halted = 1'b1;
        end
      end
    end
  end

  // Compare visible state against the model (called 2 time units after an edge).
  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check("occupancy", 64'(occupancy), 64'(sz));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    check("in_ready", 64'(in_ready), 64'((sz < 2) && !model_blk));
    check("halted", 64'(halted), 64'(model_halted));
    check("stall_cnt", 64'(stall_cnt), 64'(model_stall));
    if (sz == 0) begin
      check("idle_data", 64'(out_data), 64'(0));
      check("idle_halt", 64'(out_halt), 64'(0));
    end else begin
      check("head_data", 64'(out_data), 64'(exp_q[0].data));
      check("head_halt", 64'(out_halt), 64'(exp_q[0].halt));
    end
  endtask

  // One cycle of stimulus: settle model, check, drive, predict acceptance.
  task automatic step(input logic v, input logic [W-1:0] d, input logic h,
                      input logic r, input logic f);
    entry_t e;
    if (pend_flush) begin
      exp_q.delete();
      model_blk  = 1'b0;
      pend_flush = 1'b0;
    end
    check_state();
    model_occ = exp_q.size();
    in_valid  = v;
    in_data   = d;
    in_halt   = h;
    out_ready = r;
    flush     = f;
    if (v && (model_occ < 2) && !model_blk && !f) begin
      e.data = d;
      e.halt = h;
      exp_q.push_back(e);
      if (h) model_blk = 1'b1;
    end
    pend_flush = f;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_halt   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge CLK);
    #2;
    nRST         = 1'b1;
    exp_q.delete();
    model_occ    = 0;
    model_stall  = 0;
    model_blk    = 1'b0;
    model_halted = 1'b0;
    pend_flush   = 1'b0;
    check_state();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_halt = 1'b0; s_out_ready = 1'b0;
    nRST = 1'b0;
    @(posedge CLK);
    do_reset();

    // Saturation on the CNT_W=2 instance: stall_cnt reads 1,2,3,3,3,3.
    check("sat_in_ready", 64'(s_in_ready), 64'(1));
    s_in_valid = 1'b1;
    s_in_data  = 8'h5A;
    @(posedge CLK);
    #2;
    s_in_valid = 1'b0;
    check("sat_out_valid", 64'(s_out_valid), 64'(1));
    check("sat_out_data", 64'(s_out_data), 64'(8'h5A));
    check("sat_stall0", 64'(s_stall_cnt), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #2;
      check("sat_stall", 64'(s_stall_cnt), 64'((i + 1 < 3) ? i + 1 : 3));
    end

    // Streaming A,B,C with out_ready=1
    step(1, 16'hA001, 0, 1, 0);
    step(1, 16'hB002, 0, 1, 0);
    step(1, 16'hC003, 0, 1, 0);
    repeat (3) step(0, '0, 0, 1, 0);

    // Back-pressure: A, B absorbed, third offer refused, then drain.
    step(1, 16'hA011, 0, 0, 0);
    step(1, 16'hB012, 0, 0, 0);
    step(1, 16'hEEEE, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // Flush while full together with a new input C.
    step(1, 16'hA021, 0, 0, 0);
    step(1, 16'hB022, 0, 0, 0);
    step(1, 16'hC023, 0, 0, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // Halt blocking, then flush releases the block (halted stays set).
    step(1, 16'h4A17, 1, 1, 0);
    repeat (3) step(1, 16'hD0D0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    step(1, 16'hD0D1, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // Flush with a halt at the input: the halt is dropped and block stays clear.
    step(1, 16'h4A18, 1, 1, 1);
    step(1, 16'hD0D2, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // Reset mid-stream while full.
    step(1, 16'hA031, 0, 0, 0);
    step(1, 16'hB032, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    do_reset();

    // Randomized traffic with varying back-pressure phases.
    for (int i = 0; i < 3000; i++) begin
      logic         v, h, r, f;
      logic [W-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      h = ($urandom_range(0, 19) == 0);
      if (((i / 300) % 2) == 0) r = ($urandom_range(0, 3) != 0);
      else                      r = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(v, d, h, r, f);
    end
    step(0, '0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
